// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - WIDTH-bit handshaked multi-cycle ALU with registered results and status flags
// Non-MUL ops complete at the accept edge; MUL runs a WIDTH-step shift-add, then loads the result.
module alu_seq #(
   parameter int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [2:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_hi,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_NOT = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] prod;

   logic [WIDTH-1:0]   b_eff;
   logic [WIDTH:0]     add_sum;
   logic               add_ovf;
   logic               is_arith;
   logic [WIDTH-1:0]   res;
   logic [WIDTH:0]     step_sum;

   always_comb begin
      b_eff    = (sel == OP_SUB) ? ~b : b;
      add_sum  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
      add_ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      is_arith = (sel == OP_ADD) || (sel == OP_SUB);
      case (sel)
         OP_ADD, OP_SUB: res = add_sum[WIDTH-1:0];
         OP_NOT:         res = ~a;
         OP_AND:         res = a & b;
         OP_OR:          res = a | b;
         OP_XOR:         res = a ^ b;
         OP_MUL:         res = '0;
         default:        res = ~(a ^ b);
      endcase
   end

   // Add-then-shift: the carry out of the high half becomes the new product MSB.
   always_comb begin
      step_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         y         <= '0;
         y_hi      <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
         cnt       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         prod      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_ready && in_valid) begin
                  in_ready <= 1'b0;
                  if (sel == OP_MUL) begin
                     mcand  <= a;
                     mplier <= b;
                     prod   <= '0;
                     cnt    <= '0;
                     state  <= S_MUL;
                  end else begin
                     y         <= res;
                     y_hi      <= '0;
                     cout      <= is_arith & add_sum[WIDTH];
                     ovf       <= is_arith & add_ovf;
                     zero      <= (res == '0);
                     out_valid <= 1'b1;
                     state     <= S_DONE;
                  end
               end else begin
                  in_ready <= 1'b1;
               end
            end
            S_MUL: begin
               if (cnt == CNT_W'(WIDTH)) begin
                  y         <= prod[WIDTH-1:0];
                  y_hi      <= prod[2*WIDTH-1:WIDTH];
                  cout      <= 1'b0;
                  ovf       <= 1'b0;
                  zero      <= (prod == '0);
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  prod   <= {step_sum, prod[WIDTH-1:1]};
                  mplier <= mplier >> 1;
                  cnt    <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
// Drives and samples on the falling edge; the DUT acts on the rising edge.
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic [2:0] sel;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] y;
   logic [7:0] y_hi;
   logic       cout;
   logic       ovf;
   logic       zero;

   int n_cmp = 0;
   int n_bad = 0;
   int lat;

   alu_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .y_hi(y_hi), .cout(cout), .ovf(ovf), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Independent reference: {y_hi, y, cout, ovf, zero}
   function automatic logic [18:0] ref_alu(input logic [2:0] op, input logic [7:0] ra,
                                           input logic [7:0] rb, input logic rc);
      logic [15:0] p;
      logic [8:0]  s;
      logic [7:0]  bb;
      logic        c, v;
      p = '0; c = 1'b0; v = 1'b0;
      bb = (op == 3'd1) ? ~rb : rb;
      s = ra + bb + rc;
      case (op)
         3'd0, 3'd1: begin
            p[7:0] = s[7:0];
            c = s[8];
            v = (ra[7] == bb[7]) && (s[7] != ra[7]);
         end
         3'd2: p = ra * rb;
         3'd3: p[7:0] = ~ra;
         3'd4: p[7:0] = ra & rb;
         3'd5: p[7:0] = ra | rb;
         3'd6: p[7:0] = ra ^ rb;
         default: p[7:0] = ~(ra ^ rb);
      endcase
      return {p, c, v, (p == 16'd0)};
   endfunction

   task automatic issue(input logic [2:0] op, input logic [7:0] ia, input logic [7:0] ib,
                        input logic ic);
      int t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) check("issue_timeout", 32'd0, 32'd1);
      in_valid = 1'b1; sel = op; a = ia; b = ib; cin = ic;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Rising edges after the accept edge until out_valid is seen
   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) check("valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_res(input string tag, input logic [18:0] e);
      check({tag, "_y_hi"}, y_hi, e[18:11]);
      check({tag, "_y"}, y, e[10:3]);
      check({tag, "_cout"}, cout, e[2]);
      check({tag, "_ovf"}, ovf, e[1]);
      check({tag, "_zero"}, zero, e[0]);
   endtask

   logic [2:0]  sw_op [8];
   logic [15:0] sw_exp [8];

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sel = '0; out_ready = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_y", {y_hi, y}, 0);
      check("rst_flags", {cout, ovf, zero}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: ADD wrap
      issue(3'd0, 8'hFF, 8'h01, 1'b0);
      wait_valid(lat);
      check("add_lat", lat, 0);
      check_res("add_wrap", {8'h00, 8'h00, 1'b1, 1'b0, 1'b1});
      @(negedge clk);
      check("add_in_ready_after", in_ready, 1);
      check("add_out_valid_after", out_valid, 0);

      // 2: SUB with and without signed overflow
      issue(3'd1, 8'h80, 8'h01, 1'b1);
      wait_valid(lat);
      check_res("sub_ovf", {8'h00, 8'h7F, 1'b1, 1'b1, 1'b0});
      issue(3'd1, 8'h01, 8'h02, 1'b1);
      wait_valid(lat);
      check_res("sub_borrow", {8'h00, 8'hFF, 1'b0, 1'b0, 1'b0});

      // 3: MUL extremes
      issue(3'd2, 8'hFF, 8'hFF, 1'b1);
      check("mul_in_ready_busy", in_ready, 0);
      wait_valid(lat);
      check("mul_lat", lat, 9);
      check_res("mul_max", {8'hFE, 8'h01, 1'b0, 1'b0, 1'b0});
      issue(3'd2, 8'h00, 8'h5A, 1'b0);
      wait_valid(lat);
      check_res("mul_zero", {8'h00, 8'h00, 1'b0, 1'b0, 1'b1});

      // 4: backpressure, with an ignored request during the stall
      @(negedge clk);
      out_ready = 1'b0;
      issue(3'd6, 8'hA5, 8'h0F, 1'b0);
      in_valid = 1'b1; sel = 3'd4; a = 8'h00; b = 8'h00;
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", out_valid, 1);
         check("bp_y", y, 8'hAA);
         check("bp_in_ready", in_ready, 0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_released_valid", out_valid, 0);
      check("bp_released_ready", in_ready, 1);
      check("bp_y_held", y, 8'hAA);

      // 5: reset in the middle of a MUL
      issue(3'd2, 8'h12, 8'h34, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mrst_out_valid", out_valid, 0);
      check("mrst_in_ready", in_ready, 0);
      check("mrst_y", {y_hi, y}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mrst_idle_valid", out_valid, 0);
      issue(3'd3, 8'h0F, 8'h00, 1'b1);
      wait_valid(lat);
      check_res("not_after_rst", {8'h00, 8'hF0, 1'b0, 1'b0, 1'b0});

      // 6: opcode sweep, hand values plus reference model for flags
      sw_exp[0] = 16'h0096; sw_exp[1] = 16'h00E1; sw_exp[2] = 16'h1518; sw_exp[3] = 16'h00C3;
      sw_exp[4] = 16'h0018; sw_exp[5] = 16'h007E; sw_exp[6] = 16'h0066; sw_exp[7] = 16'h0099;
      for (int i = 0; i < 8; i++) begin
         sw_op[i] = 3'(i);
         issue(sw_op[i], 8'h3C, 8'h5A, 1'b0);
         wait_valid(lat);
         check($sformatf("sweep%0d_hand", i), {y_hi, y}, sw_exp[i]);
         check_res($sformatf("sweep%0d_ref", i), ref_alu(sw_op[i], 8'h3C, 8'h5A, 1'b0));
      end
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
